// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: writeback-select codes and load funct3 codes.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_SEL_MEM   = 2'b00,
    WB_SEL_JALR  = 2'b01,
    WB_SEL_AUIPC = 2'b10,
    WB_SEL_LUI   = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load data alignment and sign/zero extension for LB/LH/LW/LBU/LHU, plus misalign flag.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    byte_sel = rd_data[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rd_data[15:8];
      2'd2:    byte_sel = rd_data[23:16];
      2'd3:    byte_sel = rd_data[31:24];
      default: byte_sel = rd_data[7:0];
    endcase
  end

  assign half_sel = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];

  always_comb begin
    data     = rd_data;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = {16'h0, half_sel};
        misalign = addr_lo[0];
      end
      F3_LW:   misalign = (addr_lo != 2'b00);
      default: data = rd_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the RV32I core: stall/flush handling and load alignment.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_rd_data,
  input  logic [1:0]      mem_addr_lo,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] mem_auipc_res,
  input  logic [XLEN-1:0] mem_lui_imm,
  input  logic [1:0]      mem_wb_sel,
  input  logic [RD_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  output logic [XLEN-1:0] wb_load_data,
  output logic [XLEN-1:0] wb_pc_plus4,
  output logic [XLEN-1:0] wb_auipc_res,
  output logic [XLEN-1:0] wb_lui_imm,
  output logic [1:0]      wb_sel,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            wb_valid,
  output logic            wb_misalign,
  output logic [CNT_W-1:0] retire_count
);

  logic [XLEN-1:0] align_data;
  logic            align_misalign;

  load_align u_load_align (
    .rd_data  (mem_rd_data),
    .addr_lo  (mem_addr_lo),
    .funct3   (mem_funct3),
    .data     (align_data),
    .misalign (align_misalign)
  );

  logic            load_misalign;
  logic            reg_write_d;
  logic            misalign_d;
  logic            retire_d;

  // Alignment only matters when the writeback value actually comes from memory.
  assign load_misalign = (mem_wb_sel == WB_SEL_MEM) && align_misalign;
  assign reg_write_d   = mem_valid && mem_reg_write && (mem_rd != '0) && !load_misalign;
  assign misalign_d    = mem_valid && load_misalign;
  assign retire_d      = mem_valid && !load_misalign;

  logic [XLEN-1:0] load_data_q, pc_plus4_q, auipc_res_q, lui_imm_q;
  logic [1:0]      sel_q;
  logic [RD_W-1:0] rd_q;
  logic            reg_write_q, valid_q, misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      load_data_q <= '0;
      pc_plus4_q  <= '0;
      auipc_res_q <= '0;
      lui_imm_q   <= '0;
      sel_q       <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (!stall) begin
      load_data_q <= align_data;
      pc_plus4_q  <= mem_pc_plus4;
      auipc_res_q <= mem_auipc_res;
      lui_imm_q   <= mem_lui_imm;
      sel_q       <= mem_wb_sel;
      rd_q        <= mem_rd;
      reg_write_q <= reg_write_d;
      valid_q     <= mem_valid;
      misalign_q  <= misalign_d;
    end
  end

  assign wb_load_data = load_data_q;
  assign wb_pc_plus4  = pc_plus4_q;
  assign wb_auipc_res = auipc_res_q;
  assign wb_lui_imm   = lui_imm_q;
  assign wb_sel       = sel_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = reg_write_q;
  assign wb_valid     = valid_q;
  assign wb_misalign  = misalign_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (!flush && !stall && retire_d) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign retire_count = retire_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire_d;
  assign retire_count  = '0;
`endif

endmodule
